// File: rtl/fetch_unit_if.sv
// Handshake bundle between fetch_unit, the instruction memory and decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if #(
  parameter int XLEN        = 32,
  parameter int IMEM_ADDR_W = 10
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [IMEM_ADDR_W-1:0] imem_req_addr;
  logic                   imem_rsp_valid;
  logic [31:0]            imem_rsp_data;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [31:0]            inst_data;
  logic [XLEN-1:0]        inst_pc;
  logic                   inst_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues variable-latency memory requests,
// buffers returned words in order and squashes wrong-path work on a redirect.
module fetch_unit #(
  parameter int                XLEN         = 32,
  parameter int                IMEM_ADDR_W  = 10,
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  localparam int               CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  fetch_unit_if.master     bus,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [CNT_W-1:0] outstanding
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
    logic            mis;
  } entry_t;

  entry_t          fifo_mem [FIFO_DEPTH];
  logic [XLEN-1:0] tag_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] fifo_rd, fifo_wr, tag_rd, tag_wr;
  logic [CNT_W-1:0] fifo_count, discard;
  logic             halted, recovery;

  logic [CNT_W:0] occupancy;
  logic           req_fire, rsp_fire, rsp_keep, inst_fire, misaligned_target;
  entry_t         head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Outstanding requests plus buffered entries bound every queue, so neither can overflow.
  assign occupancy         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req_valid = reset && !halted && !redirect_valid && (occupancy < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc[IMEM_ADDR_W+1:2];
  assign req_fire          = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire          = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep          = rsp_fire && (discard == '0);
  assign misaligned_target = redirect_pc[1:0] != 2'b00;

  assign head           = fifo_mem[fifo_rd];
  assign bus.inst_valid = fifo_count != '0;
  assign inst_fire      = bus.inst_valid && bus.inst_ready;
  // Storage is not reset, so the head is masked while the buffer is empty.
  assign bus.inst_data       = bus.inst_valid ? head.data : '0;
  assign bus.inst_pc         = bus.inst_valid ? head.pc   : '0;
  assign bus.inst_misaligned = bus.inst_valid && head.mis;

  // NOTE: storage arrays carry no reset; the pointers and counts alone define their contents.
  always_ff @(posedge clk) begin
    if (redirect_valid) begin
      if (misaligned_target) fifo_mem[0] <= '{pc: redirect_pc, data: NOP, mis: 1'b1};
    end else if (rsp_keep) begin
      fifo_mem[fifo_wr] <= '{pc: tag_mem[tag_rd], data: bus.imem_rsp_data, mis: 1'b0};
    end
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
  end

  // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      halted      <= 1'b0;
      recovery    <= 1'b1;
    end else begin
      if (req_fire) recovery <= 1'b0;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (redirect_valid) begin
        // Every response still in flight belongs to the wrong path, including earlier discards.
        fetch_pc   <= redirect_pc;
        halted     <= misaligned_target;
        discard    <= outstanding - CNT_W'(rsp_fire);
        fifo_rd    <= '0;
        fifo_wr    <= misaligned_target ? PTR_W'(1) : '0;
        fifo_count <= misaligned_target ? CNT_W'(1) : '0;
        tag_rd     <= '0;
        tag_wr     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_wr   <= ptr_inc(tag_wr);
        end
        // Discarded responses have no tag left in the queue, so only kept ones pop it.
        if (rsp_fire) begin
          if (discard != '0) discard <= discard - CNT_W'(1);
          else               tag_rd  <= ptr_inc(tag_rd);
        end
        if (rsp_keep)  fifo_wr <= ptr_inc(fifo_wr);
        if (inst_fire) fifo_rd <= ptr_inc(fifo_rd);
        fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(inst_fire);
      end
    end
  end

`ifndef SYNTHESIS
  // Until the first request after reset, stray responses from before reset are tolerated.
  a_rsp_without_request: assert property (@(posedge clk) disable iff (!reset)
    !(bus.imem_rsp_valid && (outstanding == '0) && !recovery));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model feeds the DUT and
// a scoreboard of expected {pc, data, misaligned} entries is compared at each decode handshake.
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          AW    = 10;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; } exp_t;
  typedef struct { int due; logic [AW-1:0] addr; } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            rst_drive;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;

  fetch_unit_if #(.XLEN(XLEN), .IMEM_ADDR_W(AW)) bus ();

  fetch_unit #(.XLEN(XLEN), .IMEM_ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_pc       (fetch_pc),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0, lat = 1, last_due = 0, n_inst = 0;
  int   first_req_cyc = -1, first_inst_cyc = -1;
  exp_t exp_q[$];
  rsp_t mem_q[$];
  logic [31:0] exp_pc = RV, fpc_exp = '0;
  bit   halted_m = 0, stray = 0, saw_zero_req = 0, chk_fpc = 0, hit = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst_req_valid",  32'(bus.imem_req_valid),  0);
    check("rst_inst_valid", 32'(bus.inst_valid),      0);
    check("rst_inst_data",  bus.inst_data,            0);
    check("rst_inst_pc",    bus.inst_pc,              0);
    check("rst_inst_mis",   32'(bus.inst_misaligned), 0);
    check("rst_fetch_pc",   fetch_pc,                 RV);
    check("rst_outstanding", 32'(outstanding),        0);
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, well before the rising edge.
  task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
    logic rsp_now;
    int   due;
    exp_t e;
    @(negedge clk);
    reset = rst_drive;
    rsp_now = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_now = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (stray) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    stray = 0;
    bus.inst_ready = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (reset) begin
      check("outstanding", 32'(outstanding), 32'(mem_q.size()) + 32'(rsp_now));
      if (chk_fpc) check("fetch_pc_after_redirect", fetch_pc, fpc_exp);
      if (halted_m || redir) check("no_req_when_blocked", 32'(bus.imem_req_valid), 0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", 32'(bus.imem_req_addr), 32'(exp_pc[AW+1:2]));
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (exp_pc == 32'h0) saw_zero_req = 1;
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        mem_q.push_back('{due, exp_pc[AW+1:2]});
        exp_q.push_back('{exp_pc, mem_word(exp_pc[AW+1:2]), 1'b0});
        exp_pc += 32'd4;
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (first_inst_cyc < 0) first_inst_cyc = cyc;
        n_inst++;
        if (exp_q.size() == 0) begin
          check("inst_unexpected", 32'(bus.inst_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc",   bus.inst_pc,   e.pc);
          check("inst_data", bus.inst_data, e.data);
          check("inst_mis",  32'(bus.inst_misaligned), 32'(e.mis));
        end
      end
      chk_fpc = redir;
      if (redir) begin
        exp_q.delete();
        exp_pc   = rpc;
        fpc_exp  = rpc;
        halted_m = (rpc[1:0] != 2'b00);
        if (halted_m) exp_q.push_back('{rpc, NOP, 1'b1});
      end
    end
    cyc++;
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    rst_drive = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    #2 reset = 1'b0;
    #1 reset_checks();
    repeat (3) step(1'b1, 1'b0, '0);

    // Release with a stray response in the first cycle; L=1 streaming.
    rst_drive = 1'b1;
    stray = 1;
    lat = 1;
    step(1'b1, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, '0);
    check("first_inst_latency", 32'(first_inst_cyc - first_req_cyc), 2);
    n0 = n_inst;
    repeat (12) step(1'b1, 1'b0, '0);
    check("throughput_l1", 32'(n_inst - n0), 12);

    // Decode stall: occupancy capped, then resume without gap.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      check("occupancy_bound", 32'(exp_q.size() <= DEPTH), 1);
    end
    check("stall_req_dropped", 32'(bus.imem_req_valid), 0);
    check("stall_full", 32'(exp_q.size()), DEPTH);
    repeat (8) step(1'b1, 1'b0, '0);

    // L=3, redirect to 0x100 with two requests outstanding.
    lat = 3;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk);
      #1 hit = (outstanding == CW'(2));
      step(1'b1, hit, 32'h0000_0100);
    end
    check("redirect_with_2_outstanding", 32'(hit), 1);
    repeat (15) step(1'b1, 1'b0, '0);

    // Misaligned target halts with a single marker entry.
    step(1'b1, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      check("mis_valid", 32'(bus.inst_valid), 1);
      check("mis_flag",  32'(bus.inst_misaligned), 1);
      check("mis_pc",    bus.inst_pc, 32'h0000_0102);
      check("mis_data",  bus.inst_data, NOP);
    end
    repeat (6) step(1'b1, 1'b0, '0);
    check("halted_empty", 32'(bus.inst_valid), 0);
    check("halted_no_req", 32'(bus.imem_req_valid), 0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (12) step(1'b1, 1'b0, '0);

    // PC wrap at the top of the address space.
    lat = 1;
    saw_zero_req = 0;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b1, 1'b0, '0);
    check("wrap_reached", 32'(saw_zero_req), 1);

    // Asynchronous reset mid-stream with responses in flight.
    lat = 3;
    repeat (6) step(1'b1, 1'b0, '0);
    #1;
    reset = 1'b0;
    rst_drive = 1'b0;
    #1 reset_checks();
    exp_q.delete();
    exp_pc = RV;
    halted_m = 0;
    chk_fpc = 0;
    repeat (5) step(1'b1, 1'b0, '0);
    rst_drive = 1'b1;
    stray = 1;
    n0 = n_inst;
    repeat (12) step(1'b1, 1'b0, '0);
    check("post_reset_progress", 32'(n_inst - n0 > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
